// File: rtl/core_inst_buffer.sv
// Instruction queue between fetch F2 and decode: compacts fetch pairs into a circular FIFO and
// presents the two oldest entries. Define INST_BUF_BYPASS_EN for same-cycle empty-buffer bypass.
module core_inst_buffer #(
  parameter int unsigned DEPTH               = 8,
  parameter int unsigned ATTACHED_INFO_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush_i,
  input  logic [1:0]                          valid_i,
  input  logic [31:0]                         pc_i,
  input  logic [1:0][31:0]                    inst_i,
  input  logic [ATTACHED_INFO_WIDTH-1:0]      attached_i,
  output logic                                ready_o,
  output logic [1:0]                          valid_o,
  output logic [1:0][31:0]                    pc_o,
  output logic [1:0][31:0]                    inst_o,
  output logic [1:0][ATTACHED_INFO_WIDTH-1:0] attached_o,
  input  logic [1:0]                          ready_i
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [PtrW:0]   cnt_t;

  ptr_t wptr_q, wptr_d, rptr_q, rptr_d;
  cnt_t count_q, count_d;

  logic [31:0]                    inst_mem [DEPTH];
  logic [31:0]                    pc_mem   [DEPTH];
  logic [ATTACHED_INFO_WIDTH-1:0] att_mem  [DEPTH];

  logic            push, bypass, sel_hi;
  logic [1:0]      push_cnt, pop_cnt, byp_pop, wr_cnt;
  logic [1:0][31:0] cmp_inst, cmp_pc;
  logic [31:0]     w0_inst, w0_pc;
  ptr_t            rd_idx1, wr_idx1;
  logic            unused_pc;

  assign unused_pc = ^pc_i[2:0];

  assign ready_o  = (count_q <= cnt_t'(DEPTH - 2));
  assign push     = (|valid_i) && ready_o;
  assign push_cnt = push ? ({1'b0, valid_i[0]} + {1'b0, valid_i[1]}) : 2'd0;

  // Lowest valid slot lands in compacted lane 0; slot1 is always the younger word.
  assign cmp_inst[0] = valid_i[0] ? inst_i[0] : inst_i[1];
  assign cmp_pc[0]   = {pc_i[31:3], ~valid_i[0], 2'b00};
  assign cmp_inst[1] = inst_i[1];
  assign cmp_pc[1]   = {pc_i[31:3], 3'b100};

`ifdef INST_BUF_BYPASS_EN
  assign bypass = push && (count_q == '0);
`else
  assign bypass = 1'b0;
`endif

  assign rd_idx1 = rptr_q + ptr_t'(1);
  assign wr_idx1 = wptr_q + ptr_t'(1);

  always_comb begin
    if (bypass) begin
      valid_o    = {push_cnt == 2'd2, 1'b1};
      pc_o       = cmp_pc;
      inst_o     = cmp_inst;
      attached_o = {2{attached_i}};
    end else begin
      valid_o       = {count_q >= cnt_t'(2), count_q >= cnt_t'(1)};
      pc_o[0]       = pc_mem[rptr_q];
      pc_o[1]       = pc_mem[rd_idx1];
      inst_o[0]     = inst_mem[rptr_q];
      inst_o[1]     = inst_mem[rd_idx1];
      attached_o[0] = att_mem[rptr_q];
      attached_o[1] = att_mem[rd_idx1];
    end
  end

  assign pop_cnt = {1'b0, ready_i[0] & valid_o[0]} + {1'b0, ready_i[1] & valid_o[1]};
  // Bypassed instructions consumed this cycle never occupy an entry.
  assign byp_pop = bypass ? pop_cnt : 2'd0;
  assign wr_cnt  = push_cnt - byp_pop;
  assign sel_hi  = bypass && (pop_cnt == 2'd1);
  assign w0_inst = sel_hi ? cmp_inst[1] : cmp_inst[0];
  assign w0_pc   = sel_hi ? cmp_pc[1]   : cmp_pc[0];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      wptr_d  = wptr_q + ptr_t'(wr_cnt);
      rptr_d  = rptr_q + ptr_t'(pop_cnt - byp_pop);
      count_d = count_q + cnt_t'(push_cnt) - cnt_t'(pop_cnt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush_i) begin
      if (wr_cnt != 2'd0) begin
        inst_mem[wptr_q] <= w0_inst;
        pc_mem[wptr_q]   <= w0_pc;
        att_mem[wptr_q]  <= attached_i;
      end
      if (wr_cnt == 2'd2) begin
        inst_mem[wr_idx1] <= cmp_inst[1];
        pc_mem[wr_idx1]   <= cmp_pc[1];
        att_mem[wr_idx1]  <= attached_i;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (ready_i != 2'b10)
        else $error("core_inst_buffer: ready_i is not thermometer coded");
      assert (!((|valid_i) && !ready_o))
        else $warning("core_inst_buffer: valid_i while ready_o low, input ignored");
    end
  end
`endif

endmodule

// File: tb/tb_core_inst_buffer.sv
// Randomized bench for core_inst_buffer against a queue-based reference model.
module tb_core_inst_buffer;

  localparam int unsigned Depth = 8;
  localparam int unsigned AttW  = 32;
`ifdef INST_BUF_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] att;
  } ent_t;

  logic                  clk, rst, flush_i, ready_o;
  logic [1:0]            valid_i, valid_o, ready_i;
  logic [31:0]           pc_i;
  logic [1:0][31:0]      inst_i, pc_o, inst_o;
  logic [AttW-1:0]       attached_i;
  logic [1:0][AttW-1:0]  attached_o;

  int   total, bad;
  ent_t q[$];

  core_inst_buffer #(.DEPTH(Depth), .ATTACHED_INFO_WIDTH(AttW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush_i),
    .valid_i   (valid_i),
    .pc_i      (pc_i),
    .inst_i    (inst_i),
    .attached_i(attached_i),
    .ready_o   (ready_o),
    .valid_o   (valid_o),
    .pc_o      (pc_o),
    .inst_o    (inst_o),
    .attached_o(attached_o),
    .ready_i   (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, compare outputs mid-cycle, then advance the model at the clock edge.
  task automatic step(input logic fl, input logic [1:0] vi, input logic [31:0] pc,
                      input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] att,
                      input logic [1:0] ri);
    ent_t inc[$];
    ent_t vis[$];
    bit   rdy;
    int   npop;
    flush_i    = fl;
    valid_i    = vi;
    pc_i       = pc;
    inst_i[0]  = i0;
    inst_i[1]  = i1;
    attached_i = att;
    ready_i    = ri;
    #4;
    rdy = (q.size() <= Depth - 2);
    if (vi[0]) inc.push_back('{pc: {pc[31:3], 3'b000}, inst: i0, att: att});
    if (vi[1]) inc.push_back('{pc: {pc[31:3], 3'b100}, inst: i1, att: att});
    vis = q;
    if (Byp && q.size() == 0 && rdy && inc.size() != 0) vis = inc;
    check_eq("ready_o", 64'(ready_o), 64'(rdy));
    check_eq("valid_o", 64'(valid_o),
             64'(vis.size() >= 2 ? 2'b11 : (vis.size() == 1 ? 2'b01 : 2'b00)));
    npop = 0;
    for (int k = 0; k < 2; k++) begin
      if (k < vis.size()) begin
        check_eq(k == 0 ? "pc0" : "pc1", 64'(pc_o[k]), 64'(vis[k].pc));
        check_eq(k == 0 ? "inst0" : "inst1", 64'(inst_o[k]), 64'(vis[k].inst));
        check_eq(k == 0 ? "att0" : "att1", 64'(attached_o[k]), 64'(vis[k].att));
        if (ri[k] && npop == k) npop++;
      end
    end
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (rdy) foreach (inc[j]) q.push_back(inc[j]);
      repeat (npop) void'(q.pop_front());
    end
    #1;
  endtask

  task automatic idle(input logic [1:0] ri);
    step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, ri);
  endtask

  initial begin
    logic [1:0] ri_tab [3];
    logic [1:0] vi;
    logic [31:0] rpc;
    total = 0;
    bad   = 0;
    ri_tab[0] = 2'b00;
    ri_tab[1] = 2'b01;
    ri_tab[2] = 2'b11;
    rst = 1'b1; flush_i = 1'b0; valid_i = '0; pc_i = '0; inst_i = '0;
    attached_i = '0; ready_i = '0;
    #12;
    check_eq("rst_valid", 64'(valid_o), 64'(2'b00));
    check_eq("rst_ready", 64'(ready_o), 64'(1'b1));
    rst = 1'b0;
    @(posedge clk); #1;

    // Pair push, then observe head without popping.
    step(1'b0, 2'b11, 32'h1c000000, 32'hAAAA0000, 32'hBBBB0000, 32'h11, 2'b00);
    check_eq("t1_valid", 64'(valid_o), 64'(2'b11));
    check_eq("t1_pc0", 64'(pc_o[0]), 64'h1c000000);
    check_eq("t1_pc1", 64'(pc_o[1]), 64'h1c000004);
    idle(2'b11);
    idle(2'b00);

    // Slot1-only push into empty buffer.
    step(1'b0, 2'b10, 32'h1c000008, 32'hDEAD0000, 32'hCCCC0000, 32'h22, 2'b00);
    check_eq("t2_pc0", 64'(pc_o[0]), 64'h1c00000c);
    check_eq("t2_inst0", 64'(inst_o[0]), 64'hCCCC0000);
    idle(2'b01);

    // Fill to full, attempt an ignored push, then drain two.
    for (int i = 0; i < 4; i++)
      step(1'b0, 2'b11, 32'h2000_0000 + 32'(i * 8), 32'(i * 2), 32'(i * 2 + 1), 32'(i), 2'b00);
    check_eq("t3_full_ready", 64'(ready_o), 64'(1'b0));
    step(1'b0, 2'b11, 32'h3000_0000, 32'hEEEE, 32'hFFFF, 32'h5, 2'b00);
    idle(2'b11);
    check_eq("t3_ready_back", 64'(ready_o), 64'(1'b1));
    for (int i = 0; i < 6; i++) idle(2'b11);

    // Push two / pop one across the pointer wrap.
    for (int i = 0; i < 20; i++)
      step(1'b0, 2'b11, 32'h4000_0000 + 32'(i * 8), 32'h100 + 32'(i), 32'h200 + 32'(i),
           32'(i), 2'b01);
    for (int i = 0; i < 6; i++) idle(2'b11);

    // Flush at count 5 with colliding push and pops.
    step(1'b0, 2'b11, 32'h5000_0000, 32'h1, 32'h2, 32'h0, 2'b00);
    step(1'b0, 2'b11, 32'h5000_0008, 32'h3, 32'h4, 32'h0, 2'b00);
    step(1'b0, 2'b01, 32'h5000_0010, 32'h5, 32'h6, 32'h0, 2'b00);
    step(1'b1, 2'b11, 32'h5000_0018, 32'h7, 32'h8, 32'h0, 2'b11);
    check_eq("t5_valid", 64'(valid_o), 64'(2'b00));
    step(1'b0, 2'b01, 32'h6000_0000, 32'h9, 32'hA, 32'h0, 2'b00);
    idle(2'b11);

    // Empty buffer, pair push with single pop (bypass-dependent latency).
    step(1'b0, 2'b11, 32'h7000_0000, 32'hB, 32'hC, 32'h3, 2'b01);
    idle(2'b00);
    idle(2'b11);

    // Asynchronous reset mid-operation.
    step(1'b0, 2'b11, 32'h7100_0000, 32'hD, 32'hE, 32'h4, 2'b00);
    valid_i = '0; ready_i = '0;
    #2 rst = 1'b1;
    #1;
    check_eq("arst_valid", 64'(valid_o), 64'(2'b00));
    check_eq("arst_ready", 64'(ready_o), 64'(1'b1));
    q.delete();
    #2 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 400; i++) begin
      vi  = 2'($urandom_range(0, 3));
      rpc = {$urandom, 3'b000} >> 3 << 3;
      if (q.size() > Depth - 2 && ($urandom_range(0, 7) != 0)) vi = 2'b00;
      step(($urandom_range(0, 24) == 0), vi, rpc, $urandom, $urandom, $urandom,
           ri_tab[$urandom_range(0, 2)]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
